// File: rtl/dld_pkg.sv
// dld_pkg: shared tracker state encoding and sample width
package dld_pkg;
    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} trk_state_t;
    localparam int SAMPLE_W = 16;
endpackage

// File: rtl/Comparator16bit.sv
// Comparator16bit: unsigned magnitude compare; ports a/b in, gt (a>b), eq (a==b) out
module Comparator16bit
    import dld_pkg::*;
(
    input  logic [SAMPLE_W-1:0] A,
    input  logic [SAMPLE_W-1:0] B,
    output logic                GT,
    output logic                EQ
);
    assign GT = A > B;
    assign EQ = A == B;
endmodule

// File: rtl/extreme_tracker16.sv
// extreme_tracker16: frame max/min tracker; ports clk rst start len din din_valid -> din_ready max_val min_val max_idx min_idx done len_err busy
module extreme_tracker16
    import dld_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [CNT_W-1:0]    len,
    input  logic [SAMPLE_W-1:0] din,
    input  logic                din_valid,
    output logic                din_ready,
    output logic [SAMPLE_W-1:0] max_val,
    output logic [SAMPLE_W-1:0] min_val,
    output logic [CNT_W-1:0]    max_idx,
    output logic [CNT_W-1:0]    min_idx,
    output logic                done,
    output logic                len_err,
    output logic                busy
);
    trk_state_t       state, nxt;
    logic [CNT_W-1:0] cnt, len_q;
    logic             zlen, acc, last, max_gt, max_eq, min_gt, min_eq;

    Comparator16bit cmp_max (.A(din), .B(max_val), .GT(max_gt), .EQ(max_eq));
    Comparator16bit cmp_min (.A(min_val), .B(din), .GT(min_gt), .EQ(min_eq));

    assign acc       = state == ST_RUN && din_valid;
    assign last      = cnt == len_q - CNT_W'(1);
    assign din_ready = state == ST_RUN;
    assign done      = state == ST_DONE;
    assign len_err   = done && zlen;
    assign busy      = state != ST_IDLE;

    always_comb begin
        nxt = ST_IDLE;
        if (state == ST_IDLE)
            nxt = start ? (len == '0 ? ST_DONE : ST_RUN) : ST_IDLE;
        else if (state == ST_RUN)
            nxt = acc && last ? ST_DONE : ST_RUN;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            len_q   <= '0;
            zlen    <= 1'b0;
            max_val <= '0;
            min_val <= '0;
            max_idx <= '0;
            min_idx <= '0;
        end else begin
            state <= nxt;
            if (state == ST_IDLE && start) begin
                zlen <= len == '0;
                if (len == '0) begin
                    max_val <= '0;
                    min_val <= '0;
                    max_idx <= '0;
                    min_idx <= '0;
                end else begin
                    len_q <= len;
                    cnt   <= '0;
                end
            end
            if (acc) begin
                cnt <= cnt + CNT_W'(1);
                if (cnt == '0) begin
                    max_val <= din;
                    min_val <= din;
                    max_idx <= '0;
                    min_idx <= '0;
                end else begin
                    if (max_gt && !max_eq) begin
                        max_val <= din;
                        max_idx <= cnt;
                    end
                    if (min_gt && !min_eq) begin
                        min_val <= din;
                        min_idx <= cnt;
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_extreme_tracker16.sv
// tb_extreme_tracker16: directed scoreboard bench for extreme_tracker16
module tb_extreme_tracker16;
    typedef struct packed {
        logic [15:0] mx;
        logic [15:0] mn;
        logic [7:0]  mxi;
        logic [7:0]  mni;
        logic        lerr;
    } exp_t;

    logic        clk = 1'b0, rst = 1'b1, start = 1'b0, din_valid = 1'b0;
    logic [7:0]  len = '0;
    logic [15:0] din = '0;
    logic        din_ready, done, len_err, busy;
    logic [15:0] max_val, min_val;
    logic [7:0]  max_idx, min_idx;
    exp_t        sb[$];
    exp_t        prev = '0;
    int          n_chk = 0, n_fail = 0;
    logic [15:0] s[8];

    extreme_tracker16 #(.CNT_W(8)) dut (
        .clk(clk), .rst(rst), .start(start), .len(len), .din(din),
        .din_valid(din_valid), .din_ready(din_ready), .max_val(max_val),
        .min_val(min_val), .max_idx(max_idx), .min_idx(min_idx),
        .done(done), .len_err(len_err), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
        n_chk++;
        assert (o === e) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
        end
    endtask

    task automatic chk_res(input string tag, input exp_t e);
        chk({tag, "_max"}, max_val, e.mx);
        chk({tag, "_min"}, min_val, e.mn);
        chk({tag, "_maxi"}, max_idx, e.mxi);
        chk({tag, "_mini"}, min_idx, e.mni);
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_lerr"}, len_err, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_rdy"}, din_ready, 0);
    endtask

    task automatic run_frame(input int n, input int gap, input bit hold);
        exp_t m, g;
        m = prev;
        m.lerr = 1'b0;
        start = 1'b1;
        len = 8'(n);
        @(posedge clk); #1;
        if (!hold) start = 1'b0;
        len = '0;
        chk("run_busy", busy, 1);
        chk("run_rdy", din_ready, 1);
        chk_res("hold", prev);
        for (int i = 0; i < n; i++) begin
            for (int k = 0; k < gap; k++) begin
                din_valid = 1'b0;
                din = 16'($urandom);
                @(posedge clk); #1;
                chk_res("stall", m);
                chk("stall_done", done, 0);
            end
            din = s[i];
            din_valid = 1'b1;
            if (i == 0) begin
                m.mx = s[i]; m.mn = s[i]; m.mxi = 0; m.mni = 0;
            end else begin
                if (s[i] > m.mx) begin m.mx = s[i]; m.mxi = 8'(i); end
                if (s[i] < m.mn) begin m.mn = s[i]; m.mni = 8'(i); end
            end
            if (i == n - 1) sb.push_back(m);
            @(posedge clk); #1;
            din_valid = 1'b0;
            if (i < n - 1) begin
                chk_res("run", m);
                chk("run_done", done, 0);
            end
        end
        chk("done", done, 1);
        chk("done_lerr", len_err, 0);
        chk("done_rdy", din_ready, 0);
        chk("sb_nonempty", sb.size(), 1);
        g = sb.pop_front();
        chk_res("final", g);
        prev = g;
        @(posedge clk); #1;
        start = 1'b0;
        chk_idle("after");
        chk_res("after", g);
    endtask

    initial begin
        #12;
        chk_idle("reset");
        chk_res("reset", '0);
        rst = 1'b0;
        @(posedge clk); #1;

        s = '{16'd5, 16'd9, 16'd3, 16'd9, 0, 0, 0, 0};
        run_frame(4, 0, 0);

        s = '{16'hFFFF, 16'h0000, 16'h8000, 0, 0, 0, 0, 0};
        run_frame(3, 2, 0);

        start = 1'b1;
        len = '0;
        sb.push_back('{mx: 0, mn: 0, mxi: 0, mni: 0, lerr: 1});
        @(posedge clk); #1;
        start = 1'b0;
        chk("zl_done", done, 1);
        chk("zl_lerr", len_err, sb[0].lerr);
        chk("zl_rdy", din_ready, 0);
        chk_res("zl", sb.pop_front());
        prev = '0;
        @(posedge clk); #1;
        chk_idle("zl_after");

        s = '{16'h1234, 0, 0, 0, 0, 0, 0, 0};
        run_frame(1, 0, 0);

        start = 1'b1;
        len = 8'd5;
        @(posedge clk); #1;
        start = 1'b0;
        din = 16'd100; din_valid = 1'b1;
        @(posedge clk); #1;
        din = 16'd50;
        @(posedge clk); #1;
        chk("mid_max", max_val, 100);
        chk("mid_min", min_val, 50);
        #2 rst = 1'b1;
        #1;
        chk_idle("async_rst");
        chk_res("async_rst", '0);
        @(posedge clk); #1;
        rst = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(posedge clk); #1;
            chk_idle("post_rst");
            chk_res("post_rst", '0);
        end
        din_valid = 1'b0;
        prev = '0;

        s = '{16'd7, 16'd7, 0, 0, 0, 0, 0, 0};
        run_frame(2, 0, 0);

        s = '{16'd10, 16'd20, 16'd5, 0, 0, 0, 0, 0};
        run_frame(3, 0, 1);
        s = '{16'd1, 16'd2, 0, 0, 0, 0, 0, 0};
        run_frame(2, 1, 0);

        chk("sb_empty", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
